// File: rtl/i2s_tx_if.sv
// Sample-pair handshake and I2S serial lines between the audio source and the I2S transmitter.
interface i2s_tx_if;
    logic [15:0] din_l;
    logic [15:0] din_r;
    logic        din_valid;
    logic        din_ready;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        underrun;

    modport master (output din_l, din_r, din_valid,
                    input  din_ready, bclk, lrclk, sdata, underrun);
    modport slave  (input  din_l, din_r, din_valid,
                    output din_ready, bclk, lrclk, sdata, underrun);
endinterface

// File: rtl/i2s_tx.sv
// Philips-format I2S transmitter: one pending stereo pair is buffered and serialized
// MSB first, with bclk/lrclk generated from clk. All outputs are registered.
module i2s_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic     clk,
    input  logic     rst,
    i2s_tx_if.slave  bus
);
    logic [7:0]  div_cnt;
    logic [4:0]  bit_cnt;
    logic [31:0] word;
    logic [31:0] pend;
    logic        pend_full;

    logic        wrap, fall, load, accept, pend_full_nxt;
    logic [4:0]  bit_nxt, sel;
    logic [31:0] word_src;

    always_comb begin
        wrap          = (div_cnt == 8'(CLK_DIV - 1));
        fall          = wrap && bus.bclk;
        bit_nxt       = bit_cnt + 5'd1;
        load          = fall && (bit_nxt == 5'd1);
        accept        = bus.din_valid && !pend_full;
        // The word entering slot 1 is the pending pair if one is waiting, else the old word repeats.
        word_src      = (load && pend_full) ? pend : word;
        // Slot k carries W[32-k]; for slot 0 this wraps to W[0], the previous frame's right LSB.
        sel           = 5'd0 - bit_nxt;
        pend_full_nxt = accept || (pend_full && !load);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt       <= '0;
            bit_cnt       <= 5'd31;
            word          <= '0;
            pend          <= '0;
            pend_full     <= 1'b0;
            bus.din_ready <= 1'b1;
            bus.bclk      <= 1'b0;
            bus.lrclk     <= 1'b0;
            bus.sdata     <= 1'b0;
            bus.underrun  <= 1'b0;
        end else begin
            div_cnt      <= wrap ? 8'd0 : div_cnt + 8'd1;
            bus.underrun <= 1'b0;
            if (wrap) bus.bclk <= ~bus.bclk;
            if (fall) begin
                bit_cnt   <= bit_nxt;
                bus.lrclk <= bit_nxt[4];
                bus.sdata <= word_src[sel];
            end
            if (load) begin
                word <= word_src;
                if (!pend_full) bus.underrun <= 1'b1;
            end
            // A handshake on the load cycle fills pending for the next frame; no bypass into word.
            if (accept) pend <= {bus.din_l, bus.din_r};
            pend_full     <= pend_full_nxt;
            bus.din_ready <= !pend_full_nxt;
        end
    end
endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx with CLK_DIV=2: edge n is the n-th posedge after reset release,
// so slot k of frame f is entered at edge 4*(32*f+k+1) and slot 1 (load) at 8+128*f.
module tb_i2s_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edge_n = 0;
    int   nchk = 0;
    int   nfail = 0;

    i2s_tx_if bus();
    i2s_tx #(.CLK_DIV(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int e);
        while (edge_n < e) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.din_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        edge_n = 0;
    endtask

    task automatic send_at(input int e, input logic [15:0] l, input logic [15:0] r);
        run_to(e);
        bus.din_l = l;
        bus.din_r = r;
        bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
    endtask

    // Collects slots 1..31 of frame f plus slot 0 of frame f+1, which together rebuild W.
    task automatic frame_check(input int f, input logic [31:0] exp_w, input logic exp_un,
                               input string name);
        logic [31:0] got;
        int e, lr_bad;
        e = 4 * (32 * f + 2);
        lr_bad = 0;
        got = '0;
        run_to(e);
        nchk++;
        if (bus.underrun !== exp_un) begin
            nfail++;
            $display("FAIL %s underrun at load: got %b want %b", name, bus.underrun, exp_un);
        end
        run_to(e + 1);
        nchk++;
        if (bus.underrun !== 1'b0) begin
            nfail++;
            $display("FAIL %s underrun width: got %b want 0", name, bus.underrun);
        end
        for (int k = 1; k < 32; k++) begin
            run_to(4 * (32 * f + k + 1));
            got[32 - k] = bus.sdata;
            if (bus.lrclk !== (k >= 16)) lr_bad++;
        end
        run_to(4 * (32 * (f + 1) + 1));
        got[0] = bus.sdata;
        if (bus.lrclk !== 1'b0) lr_bad++;
        nchk++;
        if (got !== exp_w) begin
            nfail++;
            $display("FAIL %s word: got %h want %h", name, got, exp_w);
        end
        nchk++;
        if (lr_bad != 0) begin
            nfail++;
            $display("FAIL %s lrclk: %0d bad slots want 0", name, lr_bad);
        end
    endtask

    task automatic test_reset();
        int sd_bad;
        do_reset();
        nchk++;
        if ({bus.bclk, bus.lrclk, bus.sdata, bus.din_ready, bus.underrun} !== 5'b00010) begin
            nfail++;
            $display("FAIL reset_outputs: got %b want 00010",
                     {bus.bclk, bus.lrclk, bus.sdata, bus.din_ready, bus.underrun});
        end
        run_to(1);
        nchk++;
        if (bus.bclk !== 1'b0) begin nfail++; $display("FAIL bclk_e1: got %b want 0", bus.bclk); end
        run_to(2);
        nchk++;
        if (bus.bclk !== 1'b1) begin nfail++; $display("FAIL bclk_rise_e2: got %b want 1", bus.bclk); end
        run_to(4);
        nchk++;
        if (bus.bclk !== 1'b0) begin nfail++; $display("FAIL bclk_fall_e4: got %b want 0", bus.bclk); end
        run_to(7);
        nchk++;
        if (bus.underrun !== 1'b0) begin nfail++; $display("FAIL underrun_e7: got %b want 0", bus.underrun); end
        sd_bad = 0;
        for (int e = 8; e < 264; e++) begin
            run_to(e);
            if (bus.sdata !== 1'b0) sd_bad++;
            if (bus.underrun !== (e == 8 || e == 136)) sd_bad++;
        end
        nchk++;
        if (sd_bad != 0) begin nfail++; $display("FAIL idle_sdata_underrun: %0d bad cycles want 0", sd_bad); end
        frame_check(2, 32'h0, 1'b1, "idle_frame2");
    endtask

    task automatic test_load();
        do_reset();
        send_at(2, 16'hA5C3, 16'h1234);
        nchk++;
        if (bus.din_ready !== 1'b0) begin nfail++; $display("FAIL load_ready_drop: got %b want 0", bus.din_ready); end
        run_to(8);
        nchk++;
        if ({bus.din_ready, bus.sdata} !== 2'b11) begin
            nfail++;
            $display("FAIL load_edge ready,sdata: got %b want 11", {bus.din_ready, bus.sdata});
        end
        frame_check(0, 32'hA5C31234, 1'b0, "load_frame0");
        frame_check(1, 32'hA5C31234, 1'b1, "load_frame1_repeat");
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_to(1);
        bus.din_l = 16'h8000;
        bus.din_r = 16'h7FFF;
        bus.din_valid = 1'b1;
        tick();
        bus.din_l = 16'h0001;
        bus.din_r = 16'hFFFF;
        run_to(7);
        nchk++;
        if (bus.din_ready !== 1'b0) begin nfail++; $display("FAIL b2b_stall: got %b want 0", bus.din_ready); end
        run_to(8);
        nchk++;
        if (bus.din_ready !== 1'b1) begin nfail++; $display("FAIL b2b_ready_at_load: got %b want 1", bus.din_ready); end
        tick();
        bus.din_valid = 1'b0;
        nchk++;
        if (bus.din_ready !== 1'b0) begin nfail++; $display("FAIL b2b_second_accept: got %b want 0", bus.din_ready); end
        frame_check(0, 32'h80007FFF, 1'b0, "b2b_frame0");
        frame_check(1, 32'h0001FFFF, 1'b0, "b2b_frame1");
    endtask

    task automatic test_underrun_repeat();
        do_reset();
        send_at(2, 16'h1357, 16'h2468);
        frame_check(0, 32'h13572468, 1'b0, "rep_frame0");
        frame_check(1, 32'h13572468, 1'b1, "rep_frame1");
        frame_check(2, 32'h13572468, 1'b1, "rep_frame2");
    endtask

    task automatic test_load_cycle_hs();
        do_reset();
        send_at(7, 16'hBEEF, 16'hCAFE);
        nchk++;
        if ({bus.underrun, bus.din_ready} !== 2'b10) begin
            nfail++;
            $display("FAIL hs_on_load underrun,ready: got %b want 10", {bus.underrun, bus.din_ready});
        end
        frame_check(0, 32'h0, 1'b1, "hs_frame0_old");
        frame_check(1, 32'hBEEFCAFE, 1'b0, "hs_frame1_new");
    endtask

    task automatic test_mid_reset();
        do_reset();
        send_at(2, 16'h1111, 16'h2222);
        send_at(9, 16'h3333, 16'h4444);
        run_to(84);
        nchk++;
        if ({bus.lrclk, bus.din_ready} !== 2'b10) begin
            nfail++;
            $display("FAIL pre_reset lrclk,ready: got %b want 10", {bus.lrclk, bus.din_ready});
        end
        run_to(85);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        edge_n = 0;
        nchk++;
        if ({bus.bclk, bus.lrclk, bus.sdata, bus.din_ready, bus.underrun} !== 5'b00010) begin
            nfail++;
            $display("FAIL mid_reset_outputs: got %b want 00010",
                     {bus.bclk, bus.lrclk, bus.sdata, bus.din_ready, bus.underrun});
        end
        run_to(2);
        nchk++;
        if (bus.bclk !== 1'b1) begin nfail++; $display("FAIL mid_reset_rise: got %b want 1", bus.bclk); end
        run_to(4);
        nchk++;
        if (bus.bclk !== 1'b0) begin nfail++; $display("FAIL mid_reset_fall: got %b want 0", bus.bclk); end
        frame_check(0, 32'h0, 1'b1, "mid_reset_frame0");
    endtask

    initial begin
        bus.din_l = '0;
        bus.din_r = '0;
        bus.din_valid = 1'b0;
        test_reset();
        test_load();
        test_back_to_back();
        test_underrun_repeat();
        test_load_cycle_hs();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Audio output stage on the far side of the sample path.
- Accepts one stereo pair of 16-bit samples per frame via a valid/ready handshake and serializes it to an external DAC over standard I2S (Philips format).
- Generates bclk and lrclk itself from the single system clock; all outputs are registered.

Parameters:
- CLK_DIV, 4, clk cycles per half bclk period (legal range 1..255); bclk period = 2*CLK_DIV clk cycles.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- din_l  in  16  left sample, two's complement.
- din_r  in  16  right sample, two's complement.
- din_valid  in  1  sample pair valid.
- din_ready  out  1  pending buffer empty; a transfer occurs on a cycle with din_valid && din_ready.
- bclk  out  1  I2S bit clock.
- lrclk  out  1  word select: 0 = left, 1 = right.
- sdata  out  1  serial data, MSB first.
- underrun  out  1  one-cycle pulse: a frame started with no new sample pair.

Behaviour:
- Reset (rst=1 at posedge):
  - Outputs: bclk=0, lrclk=0, sdata=0, din_ready=1, underrun=0.
  - Internal: div_cnt=0, bit_cnt=31, pending empty, pending=0, frame word=0.
  - Reset mid-frame aborts immediately and discards any pending pair.
- Divider:
  - div_cnt counts 0..CLK_DIV-1.
  - At the wrap, bclk toggles on the same edge.
  - A "fall event" is the edge where bclk goes 1->0.
  - After reset, the first bclk rise is at clk edge CLK_DIV and the first fall event at edge 2*CLK_DIV.
- Slots:
  - Each fall event advances bit_cnt modulo 32 (31 wraps to 0); slot k = bit_cnt value k.
  - lrclk, sdata and bit_cnt update on the same edge as the fall event, so the DAC samples on the bclk rise.
  - lrclk = 1 for k = 16..31, else 0.
- Frame word:
  - Frame word W[31:0] = {left[15:0], right[15:0]}.
  - Philips one-bit delay: during slot k (1..31) sdata = W[32-k].
  - During slot 0 sdata = previous frame word bit 0 (right LSB). After reset this is 0.
- Load, on the fall event entering slot 1:
  - If pending is full: W <= pending, pending cleared, din_ready returns to 1 on that edge, sdata <= pending left[15].
  - If pending is empty: W is reused unchanged (the previous pair is repeated) and underrun pulses high for exactly that one cycle.
  - A handshake on that same cycle fills pending for the next frame. There is no bypass into W.
- Handshake:
  - din_ready = !pending_full.
  - The transfer latches din_l and din_r into pending; din_ready drops on the next edge.
  - din_valid with din_ready=0 is ignored, and the data is not captured.
- Arithmetic: none. Samples are passed bit-exact.
- Latency: a pair accepted before a load event appears on sdata starting at that load; one pending entry gives one frame of buffering.

Test Plan:
- Reset, CLK_DIV=2, no input -> bclk period 4 clk, first fall at edge 4; lrclk period 128 clk (low for slots 0..15, high for 16..31); sdata constantly 0; underrun pulses once per frame at every slot-1 entry.
- Load L=0xA5C3, R=0x1234 before the first slot-1 entry -> sdata over slots 1..31 = A5C3 followed by 0x1234 bits 15..1; next slot 0 carries R bit0=0; no underrun for that frame; din_ready drops after the accept and returns high at the load edge.
- Two back-to-back pairs (0x8000/0x7FFF, then 0x0001/0xFFFF) with din_valid held high -> second pair stalls with din_ready=0 until the first pair loads; both frames serialize in order; the stalled data is unchanged.
- Stop supplying input after pair 0x1357/0x2468 -> following frames repeat 0x1357/0x2468 exactly; underrun pulses once per frame, each pulse 1 clk wide.
- Handshake on the exact load cycle with pending empty -> current frame repeats the old word with an underrun pulse; the new pair transmits in the following frame.
- Assert rst for 1 cycle mid right slot (bit_cnt=20) with a pair pending -> next edge shows bclk=0, lrclk=0, sdata=0, din_ready=1; the timing sequence restarts exactly as after power-up.
